// File: rtl/mbssoc_int_dispatcher_if.sv
// Signal bundle between the device/core side and the MBSsoc interrupt dispatcher.
// master: device request lines and core handshakes (the environment side).
// slave : the dispatcher itself.
interface mbssoc_int_dispatcher_if #(
   parameter int NUM_SRC = 5,
   parameter int ID_W    = 3
);
   logic [NUM_SRC-1:0] src_req;
   logic [1:0]         core_en;
   logic [1:0]         core_ack;
   logic [1:0]         core_eoi;
   logic [1:0]         int_out;
   logic [ID_W-1:0]    int_id0;
   logic [ID_W-1:0]    int_id1;
   logic [NUM_SRC-1:0] src_ack;
   logic               drop;
   logic [1:0]         timeout;

   modport master (
      output src_req, core_en, core_ack, core_eoi,
      input  int_out, int_id0, int_id1, src_ack, drop, timeout
   );

   modport slave (
      input  src_req, core_en, core_ack, core_eoi,
      output int_out, int_id0, int_id1, src_ack, drop, timeout
   );
endinterface

// File: rtl/mbssoc_int_dispatcher.sv
// Interrupt dispatcher for the dual-core MBSsoc.
// Device request edges are captured as pending interrupts, the lowest-index
// eligible source is offered to an idle enabled core (round-robin when both
// are free), and each core walks IDLE -> OFFER -> SERVICE -> IDLE through its
// ack/eoi handshake.
// Optional feature: define DISPATCH_TIMEOUT_EN to withdraw an offer that has
// not been acked within ACK_TIMEOUT cycles (timeout output pulses); without it
// an offer waits indefinitely and timeout is tied low.
module mbssoc_int_dispatcher #(
   parameter int NUM_SRC     = 5,
   parameter int ID_W        = 3,
   parameter int ACK_TIMEOUT = 16
) (
   input logic                    clk,
   input logic                    rst,
   mbssoc_int_dispatcher_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_OFFER   = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   logic [NUM_SRC-1:0]      src_prev_q, src_prev_d;
   logic [NUM_SRC-1:0]      pending_q, pending_d;
   logic [NUM_SRC-1:0]      inflight_q, inflight_d;
   logic [NUM_SRC-1:0]      src_ack_q, src_ack_d;
   logic                    drop_q, drop_d;
   logic                    rr_ptr_q, rr_ptr_d;
   logic [1:0][1:0]         state_q, state_d;
   logic [1:0][ID_W-1:0]    id_q, id_d;

   logic [NUM_SRC-1:0]      src_edge;
   logic [NUM_SRC-1:0]      eligible;
   logic [NUM_SRC-1:0]      win_oh;
   logic [ID_W-1:0]         win_id;
   logic                    win_valid;
   logic [1:0][NUM_SRC-1:0] id_oh;
   logic [1:0]              free;
   logic                    tgt;
   logic [NUM_SRC-1:0]      disp_oh;
   logic [1:0]              expire;

   // Pick the winner: lowest-index source that is pending and not already in flight
   always_comb begin
      eligible  = pending_q & ~inflight_q;
      win_valid = 1'b0;
      win_id    = '0;
      win_oh    = '0;
      for (int s = NUM_SRC - 1; s >= 0; s--) begin
         if (eligible[s]) begin
            win_valid = 1'b1;
            win_id    = ID_W'(s);
            win_oh    = '0;
            win_oh[s] = 1'b1;
         end
      end
   end

   // Decode each core's held source id into a one-hot source mask
   always_comb begin
      id_oh = '0;
      for (int c = 0; c < 2; c++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (id_q[c] == ID_W'(s)) begin
               id_oh[c][s] = 1'b1;
            end
         end
      end
   end

`ifdef DISPATCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;

   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]            timeout_q, timeout_d;

   // Count offer cycles per core; counter sits at zero outside OFFER so it starts clean
   always_comb begin
      expire    = '0;
      cnt_d     = '0;
      timeout_d = '0;
      for (int c = 0; c < 2; c++) begin
         if (state_q[c] == ST_OFFER) begin
            expire[c] = (cnt_q[c] == CNT_W'(ACK_TIMEOUT - 1)) & ~bus.core_ack[c];
            cnt_d[c]  = cnt_q[c] + CNT_W'(1);
         end
         timeout_d[c] = expire[c];
      end
   end

   // Timeout counters and the one-cycle withdrawal pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         timeout_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign expire      = '0;
   assign bus.timeout = '0;
`endif

   // Next-state: core handshakes, then dispatch, then edge capture (a fresh edge always re-pends)
   always_comb begin
      src_edge   = bus.src_req & ~src_prev_q;
      src_prev_d = bus.src_req;
      pending_d  = pending_q;
      inflight_d = inflight_q;
      rr_ptr_d   = rr_ptr_q;
      state_d    = state_q;
      id_d       = id_q;
      src_ack_d  = '0;
      drop_d     = 1'b0;
      free       = '0;
      tgt        = 1'b0;
      disp_oh    = '0;

      for (int c = 0; c < 2; c++) begin
         case (state_q[c])
            ST_OFFER: begin
               if (bus.core_ack[c]) begin
                  state_d[c] = ST_SERVICE;
                  src_ack_d  = src_ack_d | id_oh[c];
               end else if (!bus.core_en[c] || expire[c]) begin
                  state_d[c] = ST_IDLE;
                  inflight_d = inflight_d & ~id_oh[c];
                  pending_d  = pending_d | id_oh[c];
               end
            end
            ST_SERVICE: begin
               if (bus.core_eoi[c]) begin
                  state_d[c] = ST_IDLE;
                  inflight_d = inflight_d & ~id_oh[c];
               end
            end
            ST_IDLE: begin
               free[c] = bus.core_en[c];
            end
            default: begin
               state_d[c] = ST_IDLE;
            end
         endcase
      end

      if (win_valid && (free != 2'b00)) begin
         if (free == 2'b11) begin
            tgt      = rr_ptr_q;
            rr_ptr_d = ~rr_ptr_q;
         end else begin
            tgt      = free[1];
            rr_ptr_d = ~free[1];
         end
         state_d[tgt] = ST_OFFER;
         id_d[tgt]    = win_id;
         pending_d    = pending_d & ~win_oh;
         inflight_d   = inflight_d | win_oh;
         disp_oh      = win_oh;
      end

      for (int s = 0; s < NUM_SRC; s++) begin
         if (src_edge[s]) begin
            if (pending_q[s] && !disp_oh[s]) begin
               drop_d = 1'b1;
            end
            pending_d[s] = 1'b1;
         end
      end
   end

   // Register all dispatcher state; reset forgets everything including in-service interrupts
   always_ff @(posedge clk) begin
      if (rst) begin
         src_prev_q <= '0;
         pending_q  <= '0;
         inflight_q <= '0;
         src_ack_q  <= '0;
         drop_q     <= 1'b0;
         rr_ptr_q   <= 1'b0;
         state_q    <= {ST_IDLE, ST_IDLE};
         id_q       <= '0;
      end else begin
         src_prev_q <= src_prev_d;
         pending_q  <= pending_d;
         inflight_q <= inflight_d;
         src_ack_q  <= src_ack_d;
         drop_q     <= drop_d;
         rr_ptr_q   <= rr_ptr_d;
         state_q    <= state_d;
         id_q       <= id_d;
      end
   end

   assign bus.int_out = {state_q[1] == ST_OFFER, state_q[0] == ST_OFFER};
   assign bus.int_id0 = id_q[0];
   assign bus.int_id1 = id_q[1];
   assign bus.src_ack = src_ack_q;
   assign bus.drop    = drop_q;

endmodule

// File: tb/tb_mbssoc_int_dispatcher.sv
// Self-checking bench for mbssoc_int_dispatcher: a per-cycle vector table
// followed by hand-written multi-cycle sequences. Honours DISPATCH_TIMEOUT_EN.
module tb_mbssoc_int_dispatcher;

   localparam int NUM_SRC     = 5;
   localparam int ID_W        = 3;
   localparam int ACK_TIMEOUT = 16;
   localparam int NUM_VEC     = 25;

   typedef struct {
      logic       rst;
      logic [4:0] src;
      logic [1:0] en;
      logic [1:0] ack;
      logic [1:0] eoi;
      logic [1:0] exp_out;
      logic [2:0] exp_id0;
      logic [2:0] exp_id1;
      logic [4:0] exp_sack;
      logic       exp_drop;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   testsRun    = 0;
   int   testsFailed = 0;
   vec_t vecs [NUM_VEC];

   // Free-running system clock
   always #5 clk = ~clk;

   mbssoc_int_dispatcher_if #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) bus ();

   mbssoc_int_dispatcher #(
      .NUM_SRC    (NUM_SRC),
      .ID_W       (ID_W),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic drive(input logic r, input logic [4:0] src, input logic [1:0] en,
                        input logic [1:0] ack, input logic [1:0] eoi);
      rst          = r;
      bus.src_req  = src;
      bus.core_en  = en;
      bus.core_ack = ack;
      bus.core_eoi = eoi;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.rst, v.src, v.en, v.ack, v.eoi);
      tick();
   endtask

   initial begin
      bool_dummy_init();
   end

   task automatic bool_dummy_init();
      drive(1'b1, 5'b0, 2'b0, 2'b0, 2'b0);
   endtask

   initial begin
      logic [1:0] outSnap;
      int         highCycles;
      logic       sawTimeout;
      logic       anyLow;
      logic       anyTo;

      //             rst  src       en     ack    eoi    out    id0   id1   sack      drop
      vecs[0]  = '{1'b1, 5'b00000, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 5'b00000, 1'b0};
      vecs[1]  = '{1'b0, 5'b00100, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 5'b00000, 1'b0};
      vecs[2]  = '{1'b0, 5'b00100, 2'b11, 2'b00, 2'b00, 2'b01, 3'd2, 3'd0, 5'b00000, 1'b0};
      vecs[3]  = '{1'b0, 5'b00100, 2'b11, 2'b01, 2'b00, 2'b00, 3'd2, 3'd0, 5'b00100, 1'b0};
      vecs[4]  = '{1'b0, 5'b00100, 2'b11, 2'b00, 2'b00, 2'b00, 3'd2, 3'd0, 5'b00000, 1'b0};
      vecs[5]  = '{1'b0, 5'b00100, 2'b11, 2'b00, 2'b01, 2'b00, 3'd2, 3'd0, 5'b00000, 1'b0};
      vecs[6]  = '{1'b0, 5'b00000, 2'b11, 2'b00, 2'b00, 2'b00, 3'd2, 3'd0, 5'b00000, 1'b0};
      vecs[7]  = '{1'b1, 5'b00000, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 5'b00000, 1'b0};
      vecs[8]  = '{1'b0, 5'b10001, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 5'b00000, 1'b0};
      vecs[9]  = '{1'b0, 5'b10001, 2'b11, 2'b00, 2'b00, 2'b01, 3'd0, 3'd0, 5'b00000, 1'b0};
      vecs[10] = '{1'b0, 5'b10001, 2'b11, 2'b00, 2'b00, 2'b11, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[11] = '{1'b0, 5'b10001, 2'b11, 2'b11, 2'b00, 2'b00, 3'd0, 3'd4, 5'b10001, 1'b0};
      vecs[12] = '{1'b0, 5'b10001, 2'b11, 2'b00, 2'b11, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[13] = '{1'b0, 5'b00000, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[14] = '{1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[15] = '{1'b0, 5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[16] = '{1'b0, 5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b1};
      vecs[17] = '{1'b0, 5'b00001, 2'b01, 2'b00, 2'b00, 2'b01, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[18] = '{1'b0, 5'b00000, 2'b11, 2'b01, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00001, 1'b0};
      vecs[19] = '{1'b0, 5'b00001, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[20] = '{1'b0, 5'b00001, 2'b11, 2'b00, 2'b00, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[21] = '{1'b0, 5'b00001, 2'b11, 2'b00, 2'b01, 2'b00, 3'd0, 3'd4, 5'b00000, 1'b0};
      vecs[22] = '{1'b0, 5'b00001, 2'b11, 2'b00, 2'b00, 2'b10, 3'd0, 3'd0, 5'b00000, 1'b0};
      vecs[23] = '{1'b0, 5'b00000, 2'b11, 2'b10, 2'b00, 2'b00, 3'd0, 3'd0, 5'b00001, 1'b0};
      vecs[24] = '{1'b0, 5'b00000, 2'b11, 2'b00, 2'b10, 2'b00, 3'd0, 3'd0, 5'b00000, 1'b0};

      #1;
      for (int i = 0; i < NUM_VEC; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d int_out", i), bus.int_out, vecs[i].exp_out);
         checkOutput($sformatf("vec%0d int_id0", i), bus.int_id0, vecs[i].exp_id0);
         checkOutput($sformatf("vec%0d int_id1", i), bus.int_id1, vecs[i].exp_id1);
         checkOutput($sformatf("vec%0d src_ack", i), bus.src_ack, vecs[i].exp_sack);
         checkOutput($sformatf("vec%0d drop", i), bus.drop, vecs[i].exp_drop);
         checkOutput($sformatf("vec%0d timeout", i), bus.timeout, 2'b00);
      end

      // Core0 disabled: core1 takes src 1; ack+eoi together keeps it in service, src 3 waits
      drive(1'b1, 5'b00000, 2'b10, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b00010, 2'b10, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b00000, 2'b10, 2'b00, 2'b00); tick();
      checkOutput("t3 offer core1", bus.int_out, 2'b10);
      checkOutput("t3 id1 src1", bus.int_id1, 3'd1);
      drive(1'b0, 5'b00000, 2'b10, 2'b10, 2'b10); tick();
      checkOutput("t3 src_ack", bus.src_ack, 5'b00010);
      drive(1'b0, 5'b01000, 2'b10, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b00000, 2'b10, 2'b00, 2'b00); tick();
      tick();
      checkOutput("t3 src3 held while servicing", bus.int_out, 2'b00);
      drive(1'b0, 5'b00000, 2'b10, 2'b00, 2'b10); tick();
      checkOutput("t3 eoi cycle", bus.int_out, 2'b00);
      drive(1'b0, 5'b00000, 2'b10, 2'b00, 2'b00); tick();
      checkOutput("t3 src3 offered", bus.int_out, 2'b10);
      checkOutput("t3 id1 src3", bus.int_id1, 3'd3);

      // Withdraw on core_en drop with a simultaneous new edge; re-dispatch to core1
      drive(1'b1, 5'b00000, 2'b11, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b01000, 2'b11, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b00000, 2'b11, 2'b00, 2'b00); tick();
      checkOutput("t5 offer core0", bus.int_out, 2'b01);
      checkOutput("t5 id0 src3", bus.int_id0, 3'd3);
      drive(1'b0, 5'b01000, 2'b10, 2'b00, 2'b00); tick();
      checkOutput("t5 withdrawn", bus.int_out, 2'b00);
      checkOutput("t5 no drop on withdraw edge", bus.drop, 1'b0);
      tick();
      checkOutput("t5 redispatch core1", bus.int_out, 2'b10);
      checkOutput("t5 id1 src3", bus.int_id1, 3'd3);
      checkOutput("t5 no drop", bus.drop, 1'b0);

      // Offer without ack: bounded by ACK_TIMEOUT when enabled, otherwise held
      drive(1'b1, 5'b00000, 2'b11, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b00100, 2'b11, 2'b00, 2'b00); tick();
      drive(1'b0, 5'b00000, 2'b11, 2'b00, 2'b00); tick();
      checkOutput("t6 offer core0", bus.int_out, 2'b01);
`ifdef DISPATCH_TIMEOUT_EN
      highCycles = 1;
      sawTimeout = 1'b0;
      outSnap    = 2'b11;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.int_out[0]) begin
            highCycles++;
         end else begin
            sawTimeout = bus.timeout[0];
            outSnap    = bus.int_out;
            break;
         end
      end
      checkOutput("t6 offer length", highCycles, ACK_TIMEOUT);
      checkOutput("t6 timeout pulse", sawTimeout, 1'b1);
      checkOutput("t6 both idle after withdraw", outSnap, 2'b00);
      tick();
      checkOutput("t6 re-pended to core1", bus.int_out, 2'b10);
      checkOutput("t6 id1 src2", bus.int_id1, 3'd2);
      checkOutput("t6 timeout single cycle", bus.timeout, 2'b00);
`else
      anyLow = 1'b0;
      anyTo  = 1'b0;
      for (int i = 0; i < 2 * ACK_TIMEOUT; i++) begin
         tick();
         anyLow = anyLow | ~bus.int_out[0];
         anyTo  = anyTo | (|bus.timeout);
      end
      checkOutput("t6 offer held", anyLow, 1'b0);
      checkOutput("t6 timeout quiet", anyTo, 1'b0);
      checkOutput("t6 id0 src2", bus.int_id0, 3'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
